// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin arbiter in front of a small shared 3-bit ALU.
// One operation at a time: IDLE -> EXEC (L cycles) -> DONE (one-cycle done pulse) -> IDLE.
// DIV/MOD run as a 3-step restoring divider, one quotient bit per cycle, MSB first.
module alu_req_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [2:0] a0,
  input  logic [2:0] b0,
  input  logic [2:0] a1,
  input  logic [2:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done,
  output logic [4:0] result,
  output logic       err,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_LT  = 3'b101;
  localparam logic [2:0] OP_EQ  = 3'b110;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
  } alu_req_t;

  logic [1:0] state;
  logic [1:0] cnt;
  logic       last;      // index of the requester granted most recently
  alu_req_t   cap;       // operation captured at the grant edge
  logic [2:0] dvd;       // dividend bits still to be shifted in, MSB first
  logic [2:0] rem;       // partial remainder
  logic [1:0] quo;       // quotient bits produced so far

  logic       win1;
  alu_req_t   sel;
  logic [1:0] lat_m1;

  logic [3:0] rem_sh, rem_sub, rem_t;
  logic       ge;
  logic [2:0] quo_nx;
  logic [3:0] sum;
  logic [2:0] diff;
  logic [4:0] prod;
  logic [4:0] res_nx;
  logic       err_nx;

  assign busy = (state != S_IDLE);

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    win1   = req1 & (~req0 | ~last);
    sel    = win1 ? '{op: op1, a: a1, b: b1} : '{op: op0, a: a0, b: b0};
    lat_m1 = 2'd0;
    if (sel.op == OP_MUL)                         lat_m1 = 2'd1;
    else if (sel.op == OP_DIV || sel.op == OP_MOD) lat_m1 = 2'd2;
  end

  // One restoring-division step plus the final result for every opcode.
  always_comb begin
    rem_sh  = {rem, dvd[2]};
    rem_sub = rem_sh - {1'b0, cap.b};
    ge      = (rem_sh >= {1'b0, cap.b});
    rem_t   = ge ? rem_sub : rem_sh;
    quo_nx  = {quo, ge};
    sum     = {1'b0, cap.a} + {1'b0, cap.b};
    diff    = cap.a - cap.b;
    prod    = {2'b00, cap.a} * {2'b00, cap.b};
    res_nx  = 5'd0;
    err_nx  = 1'b0;
    case (cap.op)
      OP_ADD: res_nx = {1'b0, sum};
      OP_SUB: res_nx = {2'b00, diff};
      OP_MUL: res_nx = prod;
      OP_DIV: if (cap.b == 3'd0) err_nx = 1'b1; else res_nx = {2'b00, quo_nx};
      OP_MOD: if (cap.b == 3'd0) err_nx = 1'b1; else res_nx = {1'b0, rem_t};
      OP_LT:  res_nx = {4'b0000, cap.a < cap.b};
      OP_EQ:  res_nx = {4'b0000, cap.a == cap.b};
      default: err_nx = 1'b1;
    endcase
  end

  // Control FSM, capture registers and the iterative divider datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done   <= 1'b0;
      result <= 5'd0;
      err    <= 1'b0;
      cnt    <= 2'd0;
      last   <= ~RR_INIT;
      cap    <= '0;
      dvd    <= 3'd0;
      rem    <= 3'd0;
      quo    <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            gnt0  <= ~win1;
            gnt1  <= win1;
            last  <= win1;
            cap   <= sel;
            dvd   <= sel.a;
            rem   <= 3'd0;
            quo   <= 2'd0;
            cnt   <= lat_m1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == 2'd0) begin
            done   <= 1'b1;
            result <= res_nx;
            err    <= err_nx;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - 2'd1;
            rem <= rem_t[2:0];
            quo <= quo_nx[1:0];
            dvd <= {dvd[1:0], 1'b0};
          end
        end
        S_DONE: begin
          done   <= 1'b0;
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          result <= 5'd0;
          err    <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios with literal expectations, then
// random traffic, all cross-checked every cycle against an edge-schedule model.
module tb_alu_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [2:0] op0, op1, a0, b0, a1, b1;
  logic       gnt0, gnt1, done, err, busy;
  logic [4:0] result;

  always #5 clk = ~clk;

  alu_req_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done(done), .result(result), .err(err), .busy(busy)
  );

  int pass_cnt = 0;
  int total    = 0;

  // Model: a transaction is a grant edge plus the edges at which done rises and
  // the grant ends; outputs are read off that schedule.
  int  cyc = 0;
  bit  m_active;
  int  m_owner;
  bit  m_last;
  int  m_done_e, m_end_e;
  int  m_res, m_err;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  function automatic void calc(input int op, input int a, input int b,
                               output int lat, output int r, output int e);
    lat = 1; r = 0; e = 0;
    case (op)
      0: r = a + b;
      1: r = (a - b + 8) % 8;
      2: begin lat = 2; r = (a * b) % 32; end
      3: begin lat = 3; if (b == 0) e = 1; else r = a / b; end
      4: begin lat = 3; if (b == 0) e = 1; else r = a % b; end
      5: r = (a < b) ? 1 : 0;
      6: r = (a == b) ? 1 : 0;
      default: e = 1;
    endcase
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    int lat;
    @(posedge clk);
    if (rst) begin
      m_active = 0;
      m_last   = 1'b1;   // RR_INIT = 0 -> requester 0 favoured first
    end else if (m_active && cyc == m_end_e) begin
      m_active = 0;
    end else if (!m_active && (req0 || req1)) begin
      if (req0 && req1) m_owner = m_last ? 0 : 1;
      else              m_owner = req1 ? 1 : 0;
      m_last = (m_owner == 1);
      if (m_owner == 0) calc(op0, a0, b0, lat, m_res, m_err);
      else              calc(op1, a1, b1, lat, m_res, m_err);
      m_active = 1;
      m_done_e = cyc + lat;
      m_end_e  = cyc + lat + 1;
    end
    @(negedge clk);
    begin
      bit d;
      d = m_active && (cyc == m_done_e);
      chk("gnt0",   gnt0,   (m_active && m_owner == 0) ? 1 : 0);
      chk("gnt1",   gnt1,   (m_active && m_owner == 1) ? 1 : 0);
      chk("done",   done,   d);
      chk("result", result, d ? m_res : 0);
      chk("err",    err,    d ? m_err : 0);
      chk("busy",   busy,   m_active);
    end
    cyc++;
  endtask

  task automatic scramble();
    op0 = 3'($urandom); op1 = 3'($urandom);
    a0 = 3'($urandom); b0 = 3'($urandom); a1 = 3'($urandom); b1 = 3'($urandom);
  endtask

  // Issue one isolated request (from IDLE) and check the literal outcome.
  task automatic run_op(input int who, input logic [2:0] op, input logic [2:0] a,
                        input logic [2:0] b, input int lat, input int er, input int ee);
    if (who == 0) begin req0 = 1; op0 = op; a0 = a; b0 = b; req1 = 0; end
    else          begin req1 = 1; op1 = op; a1 = a; b1 = b; req0 = 0; end
    tick();
    req0 = 0; req1 = 0;
    scramble();                                 // must not disturb the captured operation
    chk("lit_gnt", (who == 0) ? gnt0 : gnt1, 1);
    repeat (lat - 1) tick();
    chk("lit_pre_done", done, 0);
    tick();
    chk("lit_done", done, 1);
    chk("lit_result", result, er);
    chk("lit_err", err, ee);
    tick();
    chk("lit_idle", busy, 0);
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    rst = 1; req0 = 0; req1 = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tick();
    chk("rst_gnt", gnt0 | gnt1, 0);
    chk("rst_out", {done, err, busy, result}, 0);
    rst = 0;
    tick();

    run_op(0, 3'b000, 3'd7, 3'd5, 1, 12, 0);   // ADD
    run_op(1, 3'b010, 3'd7, 3'd7, 2, 17, 0);   // MUL wrap
    run_op(0, 3'b001, 3'd1, 3'd3, 1, 6, 0);    // SUB wrap
    run_op(1, 3'b011, 3'd7, 3'd2, 3, 3, 0);    // DIV, operands scrambled mid-op
    run_op(0, 3'b100, 3'd7, 3'd2, 3, 1, 0);    // modulo
    run_op(0, 3'b011, 3'd5, 3'd0, 3, 0, 1);    // DIV by zero
    run_op(1, 3'b100, 3'd6, 3'd0, 3, 0, 1);    // modulo by zero
    run_op(1, 3'b111, 3'd3, 3'd3, 1, 0, 1);    // illegal
    run_op(0, 3'b101, 3'd2, 3'd6, 1, 1, 0);    // LT
    run_op(1, 3'b110, 3'd4, 3'd4, 1, 1, 0);    // EQ
    run_op(0, 3'b011, 3'd6, 3'd4, 3, 1, 0);    // DIV with nonzero remainder

    // Held contention from reset: grants alternate 0,1,0,1.
    do_reset();
    req0 = 1; req1 = 1; op0 = 0; op1 = 0;
    begin
      int k = 0;
      bit prev = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if ((gnt0 | gnt1) && !prev) begin
          chk("rr_owner", gnt1, k % 2);
          k++;
        end
        prev = gnt0 | gnt1;
      end
      chk("rr_grants", k, 4);
    end
    req0 = 0; req1 = 0;
    tick(); tick(); tick();

    // Reset mid-DIV aborts with no done; a later request is served normally.
    req0 = 1; op0 = 3'b011; a0 = 3'd7; b0 = 3'd2;
    tick();
    req0 = 0; rst = 1;
    tick();
    chk("abort_out", {gnt0, gnt1, done, err, busy, result}, 0);
    rst = 0;
    tick();
    run_op(1, 3'b011, 3'd7, 3'd3, 3, 2, 0);

    // Random traffic, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      req0 = ($urandom_range(0, 2) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      scramble();
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter: RR_INIT, 0, requester favoured on the first simultaneous request after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0, req1  in  1 each  operation request from requester 0 / 1.
REQ-005 op0, op1  in  3 each  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 LT, 110 EQ, 111 illegal.
REQ-006 a0, b0, a1, b1  in  3 each  unsigned operands per requester.
REQ-007 gnt0, gnt1  out  1 each  grant; the requester owns the shared datapath while high.
REQ-008 done  out  1  one-cycle completion pulse for the granted requester.
REQ-009 result  out  5  unsigned result, valid only while done=1.
REQ-010 err  out  1  error flag, valid only while done=1.
REQ-011 busy  out  1  high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE, EXEC and DONE; busy = (state != IDLE).
REQ-013 In IDLE, an edge with any req high SHALL select a winner, capture its op/a/b, set its gnt, load cnt = L-1 and go to EXEC.
REQ-014 Arbitration SHALL be: single requester wins; on simultaneous req the requester not granted last wins; the last-grant pointer updates at each grant.
REQ-015 Latency L SHALL be: ADD, SUB, LT, EQ and illegal = 1; MUL = 2; DIV and MOD = 3 (restoring division, one quotient bit per cycle, MSB first).
REQ-016 In EXEC, cnt SHALL decrement each edge; the edge seen with cnt==0 SHALL register result and err, set done and go to DONE.
REQ-017 Timing: for a request sampled at edge N, gnt SHALL be high from N through N+L+1 and done SHALL be high from N+L to N+L+1.
REQ-018 In DONE, the next edge SHALL clear done, gnt and err and return to IDLE; a new grant is possible at edge N+L+2 at the earliest.
REQ-019 ADD result = 4-bit sum, zero-extended; SUB = (a-b) mod 8, zero-extended; MUL = 5-bit... full 6-bit product truncated to 5 bits (max 7*7=49 -> 49 mod 32 = 17).
REQ-020 DIV result = floor(a/b); MOD = a mod b; LT = {4'b0, a<b}; EQ = {4'b0, a==b}; all zero-extended.
REQ-021 DIV or MOD with b==0 SHALL return result=0 and err=1, still after L=3 cycles.
REQ-022 Opcode 111 SHALL return result=0 and err=1 after L=1.
REQ-023 Operands SHALL be taken only from the values captured at the grant edge; input changes after grant SHALL have no effect.
REQ-024 req SHALL be ignored outside IDLE; a req still high when IDLE is re-entered counts as a new request.
REQ-025 gnt0 and gnt1 SHALL never be high at the same time; done SHALL never be high without a gnt.
REQ-026 result and err SHALL be 0 whenever done=0.

Reset
REQ-027 While rst=1 at an edge: state=IDLE, gnt0=gnt1=0, done=0, result=0, err=0, busy=0, cnt=0, last-grant pointer = !RR_INIT.
REQ-028 Reset asserted during EXEC or DONE SHALL abort the operation with no done pulse, and reset SHALL take priority over every other event on the same edge.

Verification
REQ-029 Single ADD: req0=1, op0=000, a0=7, b0=5 at edge N -> gnt0 high from N; done=1, result=12, err=0 at N+1; IDLE at N+2.
REQ-030 Contention: req0=req1=1 with RR_INIT=0 and held -> grants alternate 0,1,0,1; each done is paired with the matching gnt; gnt0 and gnt1 are never high together.
REQ-031 DIV and MOD: a=7, b=2 -> DIV result=3 after 3 cycles; MOD result=1 after 3 cycles; DIV with b=0 -> result=0, err=1 at N+3.
REQ-032 MUL wrap and SUB wrap: 7*7 -> result=17 at N+2; SUB a=1, b=3 -> result=6 at N+1.
REQ-033 Illegal opcode and operand change: op=111 -> err=1, result=0 at N+1; a1/b1 changed mid-DIV -> result uses the captured values.
REQ-034 Reset mid-DIV: rst=1 at N+1 -> all outputs 0 from N+1 with no done pulse; a request at N+3 is served normally.
